// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: owns the trap CSRs and redirects fetch on trap entry and mret.
// Latency: 2 cycles from report to first fetch at target; stall_o holds the pipe throughout.
module trap_ctrl #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        excPresent_i,
    input  logic [31:0] excCause_i,
    input  logic [31:0] trapInfo_i,
    input  logic [31:0] pc_i,
    input  logic        mret_i,
    input  logic [11:0] csrAddr_i,
    input  logic        csrWe_i,
    input  logic [31:0] csrWrData_i,
    output logic [31:0] csrRdData_o,
    output logic        csrIllegal_o,
    output logic        stall_o,
    output logic        redirect_o,
    output logic [31:0] redirectPc_o,
    output logic        mstatusMie_o,
    output logic        mieMtie_o
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_TRAP,
        ST_RET
    } state_t;

    state_t      state_q, state_d;
    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    logic        take;
    logic        mret_go;
    logic [31:0] mtvec_base;

    assign mtvec_base = {mtvec_q[31:2], 2'b00};

    always_comb begin
        state_d      = ST_RUN;
        mst_mie_d    = mst_mie_q;
        mst_mpie_d   = mst_mpie_q;
        mie_mtie_d   = mie_mtie_q;
        mtvec_d      = mtvec_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mtval_d      = mtval_q;
        take         = 1'b0;
        mret_go      = 1'b0;
        stall_o      = 1'b0;
        redirect_o   = 1'b0;
        redirectPc_o = 32'h0;

        case (state_q)
            ST_RUN: begin
                take    = excPresent_i && !(excCause_i[31] && !mst_mie_q);
                mret_go = !take && mret_i;
                stall_o = take || mret_go;
                if (take) begin
                    mepc_d     = pc_i & 32'hFFFF_FFFC;
                    mcause_d   = excCause_i;
                    mtval_d    = excCause_i[31] ? 32'h0 : trapInfo_i;
                    mst_mpie_d = mst_mie_q;
                    mst_mie_d  = 1'b0;
                    state_d    = ST_TRAP;
                end else if (mret_go) begin
                    mst_mie_d  = mst_mpie_q;
                    mst_mpie_d = 1'b1;
                    state_d    = ST_RET;
                end else if (csrWe_i) begin
                    case (csrAddr_i)
                        ADDR_MSTATUS: begin
                            mst_mie_d  = csrWrData_i[3];
                            mst_mpie_d = csrWrData_i[7];
                        end
                        ADDR_MIE:    mie_mtie_d = csrWrData_i[7];
                        ADDR_MTVEC:  mtvec_d    = csrWrData_i & 32'hFFFF_FFFD;
                        ADDR_MEPC:   mepc_d     = csrWrData_i & 32'hFFFF_FFFC;
                        ADDR_MCAUSE: mcause_d   = csrWrData_i;
                        ADDR_MTVAL:  mtval_d    = csrWrData_i;
                        default: ;
                    endcase
                end
            end
            ST_TRAP: begin
                stall_o    = 1'b1;
                redirect_o = 1'b1;
                // Vector offset uses the cause captured at entry, scaled by 4.
                if (mtvec_q[1:0] == 2'b01 && mcause_q[31])
                    redirectPc_o = mtvec_base + {mcause_q[29:0], 2'b00};
                else
                    redirectPc_o = mtvec_base;
            end
            ST_RET: begin
                stall_o      = 1'b1;
                redirect_o   = 1'b1;
                redirectPc_o = mepc_q;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        csrRdData_o  = 32'h0;
        csrIllegal_o = 1'b0;
        case (csrAddr_i)
            ADDR_MSTATUS: csrRdData_o = {24'h0, mst_mpie_q, 3'b000, mst_mie_q, 3'b000};
            ADDR_MIE:     csrRdData_o = {24'h0, mie_mtie_q, 7'h0};
            ADDR_MTVEC:   csrRdData_o = mtvec_q;
            ADDR_MEPC:    csrRdData_o = mepc_q;
            ADDR_MCAUSE:  csrRdData_o = mcause_q;
            ADDR_MTVAL:   csrRdData_o = mtval_q;
            default:      csrIllegal_o = 1'b1;
        endcase
    end

    assign mstatusMie_o = mst_mie_q;
    assign mieMtie_o    = mie_mtie_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_mtie_q <= 1'b0;
            mtvec_q    <= RESET_MTVEC;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_mtie_q <= mie_mtie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with hand-computed expectations.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        excPresent_i;
    logic [31:0] excCause_i;
    logic [31:0] trapInfo_i;
    logic [31:0] pc_i;
    logic        mret_i;
    logic [11:0] csrAddr_i;
    logic        csrWe_i;
    logic [31:0] csrWrData_i;
    logic [31:0] csrRdData_o;
    logic        csrIllegal_o;
    logic        stall_o;
    logic        redirect_o;
    logic [31:0] redirectPc_o;
    logic        mstatusMie_o;
    logic        mieMtie_o;

    int n_checks = 0;
    int n_errors = 0;

    trap_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .excPresent_i (excPresent_i),
        .excCause_i   (excCause_i),
        .trapInfo_i   (trapInfo_i),
        .pc_i         (pc_i),
        .mret_i       (mret_i),
        .csrAddr_i    (csrAddr_i),
        .csrWe_i      (csrWe_i),
        .csrWrData_i  (csrWrData_i),
        .csrRdData_o  (csrRdData_o),
        .csrIllegal_o (csrIllegal_o),
        .stall_o      (stall_o),
        .redirect_o   (redirect_o),
        .redirectPc_o (redirectPc_o),
        .mstatusMie_o (mstatusMie_o),
        .mieMtie_o    (mieMtie_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
        csrAddr_i   = addr;
        csrWrData_i = data;
        csrWe_i     = 1'b1;
        tick();
        csrWe_i     = 1'b0;
    endtask

    task automatic csr_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csrAddr_i = addr;
        #1;
        check(tag, csrRdData_o, exp);
    endtask

    task automatic report(input logic [31:0] cause, input logic [31:0] info, input logic [31:0] pc);
        excPresent_i = 1'b1;
        excCause_i   = cause;
        trapInfo_i   = info;
        pc_i         = pc;
    endtask

    initial begin
        rst = 1'b1; excPresent_i = 1'b0; excCause_i = 32'h0; trapInfo_i = 32'h0;
        pc_i = 32'h0; mret_i = 1'b0; csrAddr_i = 12'h300; csrWe_i = 1'b0; csrWrData_i = 32'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_stall", {31'h0, stall_o}, 32'h0);
        check("rst_redirect", {31'h0, redirect_o}, 32'h0);
        check("rst_redirect_pc", redirectPc_o, 32'h0);
        check("rst_mie_o", {30'h0, mstatusMie_o, mieMtie_o}, 32'h0);
        csr_chk("rst_mstatus", 12'h300, 32'h0);
        check("rst_legal", {31'h0, csrIllegal_o}, 32'h0);
        csr_chk("rst_mtvec", 12'h305, 32'h100);
        csr_chk("rst_mepc", 12'h341, 32'h0);

        // Load misalign
        report(32'd4, 32'h2001, 32'h120);
        #1;
        check("lm_stall_n", {31'h0, stall_o}, 32'h1);
        check("lm_redir_n", {31'h0, redirect_o}, 32'h0);
        tick();
        excPresent_i = 1'b0;
        #1;
        check("lm_redir", {31'h0, redirect_o}, 32'h1);
        check("lm_target", redirectPc_o, 32'h100);
        check("lm_stall_n1", {31'h0, stall_o}, 32'h1);
        csr_chk("lm_mepc", 12'h341, 32'h120);
        csr_chk("lm_mcause", 12'h342, 32'h4);
        csr_chk("lm_mtval", 12'h343, 32'h2001);
        csr_chk("lm_mstatus", 12'h300, 32'h0);
        tick();
        check("lm_stall_n2", {31'h0, stall_o}, 32'h0);
        check("lm_redir_n2", {31'h0, redirect_o}, 32'h0);
        check("lm_pc_idle", redirectPc_o, 32'h0);

        // mret with MPIE=1; a report in the RET cycle is ignored
        csr_wr(12'h300, 32'h80);
        mret_i = 1'b1;
        #1;
        check("mret_stall", {31'h0, stall_o}, 32'h1);
        tick();
        mret_i = 1'b0;
        report(32'd4, 32'h9999, 32'h500);
        #1;
        check("mret_redir", {31'h0, redirect_o}, 32'h1);
        check("mret_target", redirectPc_o, 32'h120);
        csr_chk("mret_mstatus", 12'h300, 32'h88);
        check("mret_mie_o", {31'h0, mstatusMie_o}, 32'h1);
        tick();
        excPresent_i = 1'b0;
        #1;
        check("ret_ign_stall", {31'h0, stall_o}, 32'h0);
        csr_chk("ret_ign_mepc", 12'h341, 32'h120);
        csr_chk("ret_ign_mtval", 12'h343, 32'h2001);

        // Vectored timer interrupt
        csr_wr(12'h305, 32'h203);
        csr_chk("mtvec_bit1", 12'h305, 32'h201);
        csr_wr(12'h304, 32'hFFFF_FFFF);
        csr_chk("mie_mask", 12'h304, 32'h80);
        check("mtie_o", {31'h0, mieMtie_o}, 32'h1);
        report(32'h8000_0007, 32'hDEAD, 32'h124);
        tick();
        excPresent_i = 1'b0;
        #1;
        check("vt_target", redirectPc_o, 32'h21C);
        csr_chk("vt_mtval", 12'h343, 32'h0);
        csr_chk("vt_mstatus", 12'h300, 32'h80);
        csr_chk("vt_mcause", 12'h342, 32'h8000_0007);
        tick();

        // Masked interrupt (MIE now 0)
        report(32'h8000_0003, 32'h1, 32'h300);
        #1;
        check("mask_stall", {31'h0, stall_o}, 32'h0);
        tick();
        excPresent_i = 1'b0;
        #1;
        check("mask_redir", {31'h0, redirect_o}, 32'h0);
        csr_chk("mask_mcause", 12'h342, 32'h8000_0007);
        csr_chk("mask_mepc", 12'h341, 32'h124);

        // Exception with vectored mtvec goes to base; PC low bits dropped
        report(32'd2, 32'h77, 32'h133);
        tick();
        excPresent_i = 1'b0;
        #1;
        check("vx_target", redirectPc_o, 32'h200);
        csr_chk("vx_mepc", 12'h341, 32'h130);
        tick();

        // Collision: exception + mret + mtvec write in one cycle
        csr_wr(12'h305, 32'h100);
        csr_wr(12'h300, 32'h80);
        report(32'd4, 32'h44, 32'h140);
        mret_i = 1'b1;
        csrAddr_i = 12'h305; csrWrData_i = 32'h400; csrWe_i = 1'b1;
        tick();
        excPresent_i = 1'b0; mret_i = 1'b0; csrWe_i = 1'b0;
        #1;
        check("col_target", redirectPc_o, 32'h100);
        csr_chk("col_mtvec", 12'h305, 32'h100);
        csr_chk("col_mstatus", 12'h300, 32'h00);
        csr_chk("col_mepc", 12'h341, 32'h140);
        tick();

        // CSR masking, illegal address, read-old-during-write
        csr_wr(12'h300, 32'hFFFF_FFFF);
        csr_chk("mstatus_mask", 12'h300, 32'h88);
        csr_wr(12'h7C0, 32'hFFFF_FFFF);
        csr_chk("illegal_rd", 12'h7C0, 32'h0);
        check("illegal_flag", {31'h0, csrIllegal_o}, 32'h1);
        csr_wr(12'h341, 32'hFFFF_FFFF);
        csr_chk("mepc_mask", 12'h341, 32'hFFFF_FFFC);
        csrWrData_i = 32'h55; csrWe_i = 1'b1;
        csr_chk("rd_old", 12'h342, 32'h4);
        tick();
        csrWe_i = 1'b0;
        csr_chk("rd_new", 12'h342, 32'h55);

        // Vector address wraps modulo 2^32
        csr_wr(12'h305, 32'hFFFF_FFFD);
        report(32'h8000_0003, 32'h0, 32'h10);
        tick();
        excPresent_i = 1'b0;
        #1;
        check("wrap_target", redirectPc_o, 32'h8);
        tick();

        // Reset during TRAP
        report(32'd4, 32'h1234, 32'h200);
        tick();
        excPresent_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rt_redir", {31'h0, redirect_o}, 32'h0);
        check("rt_stall", {31'h0, stall_o}, 32'h0);
        csr_chk("rt_mtvec", 12'h305, 32'h100);
        csr_chk("rt_mepc", 12'h341, 32'h0);
        csr_chk("rt_mcause", 12'h342, 32'h0);
        csr_chk("rt_mtval", 12'h343, 32'h0);
        csr_chk("rt_mstatus", 12'h300, 32'h0);
        csr_chk("rt_mie", 12'h304, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
